// File: rtl/instr_encoder.sv
// RV32I instruction encoder: mnemonic + register fields + immediate -> 32-bit machine word.
// Latency: 1 cycle from accept to out_valid; one word per clock when out_ready stays high.
// Backpressure: in_ready = ~out_valid | out_ready; the held word is stable while out_ready is low.
//
// Ports:
//   clk, rst                 : clock (rising edge), synchronous active-high reset
//   in_valid/in_ready        : request handshake; in_mnem/in_rd/in_rs1/in_rs2/in_imm carry the request
//   out_valid/out_ready      : result handshake; out_word is the encoding, out_err flags a rejected request
//   emit_cnt, err_cnt        : transferred words (wrapping) and transferred error words (saturating)
module instr_encoder #(
  parameter int CNT_W = 16,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       in_mnem,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_word,
  output logic             out_err,
  output logic [CNT_W-1:0] emit_cnt,
  output logic [ERR_W-1:0] err_cnt
);

  localparam logic [31:0] NOP = 32'h0000_0013;  // addi x0,x0,0

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J, FMT_X} fmt_e;

  fmt_e       fmt;
  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       legal;
  logic [31:0] enc;

  logic             out_valid_q, out_valid_d;
  logic [31:0]      out_word_q,  out_word_d;
  logic             out_err_q,   out_err_d;
  logic [CNT_W-1:0] emit_cnt_q,  emit_cnt_d;
  logic [ERR_W-1:0] err_cnt_q,   err_cnt_d;

  logic accept, xfer;

  // Mnemonic code -> format and fixed opcode fields; unknown codes fall to FMT_X.
  always_comb begin
    fmt = FMT_X;
    opc = 7'd0;
    f3  = 3'd0;
    f7  = 7'd0;
    case (in_mnem)
      6'd0:  begin fmt = FMT_U;  opc = OP_LUI;                          end
      6'd1:  begin fmt = FMT_U;  opc = OP_AUIPC;                        end
      6'd2:  begin fmt = FMT_R;  opc = OP_REG;    f3 = 3'b000;          end
      6'd3:  begin fmt = FMT_R;  opc = OP_REG;    f3 = 3'b000; f7 = F7_ALT; end
      6'd4:  begin fmt = FMT_R;  opc = OP_REG;    f3 = 3'b110;          end
      6'd5:  begin fmt = FMT_R;  opc = OP_REG;    f3 = 3'b111;          end
      6'd6:  begin fmt = FMT_R;  opc = OP_REG;    f3 = 3'b100;          end
      6'd7:  begin fmt = FMT_R;  opc = OP_REG;    f3 = 3'b001;          end
      6'd8:  begin fmt = FMT_R;  opc = OP_REG;    f3 = 3'b101; f7 = F7_ALT; end
      6'd9:  begin fmt = FMT_R;  opc = OP_REG;    f3 = 3'b101;          end
      6'd10: begin fmt = FMT_R;  opc = OP_REG;    f3 = 3'b010;          end
      6'd11: begin fmt = FMT_R;  opc = OP_REG;    f3 = 3'b011;          end
      6'd12: begin fmt = FMT_I;  opc = OP_LOAD;   f3 = 3'b000;          end
      6'd13: begin fmt = FMT_I;  opc = OP_LOAD;   f3 = 3'b001;          end
      6'd14: begin fmt = FMT_I;  opc = OP_LOAD;   f3 = 3'b010;          end
      6'd15: begin fmt = FMT_I;  opc = OP_LOAD;   f3 = 3'b100;          end
      6'd16: begin fmt = FMT_I;  opc = OP_LOAD;   f3 = 3'b101;          end
      6'd17: begin fmt = FMT_I;  opc = OP_IMM;    f3 = 3'b000;          end
      6'd18: begin fmt = FMT_I;  opc = OP_IMM;    f3 = 3'b110;          end
      6'd19: begin fmt = FMT_I;  opc = OP_IMM;    f3 = 3'b111;          end
      6'd20: begin fmt = FMT_I;  opc = OP_IMM;    f3 = 3'b100;          end
      6'd21: begin fmt = FMT_SH; opc = OP_IMM;    f3 = 3'b001;          end
      6'd22: begin fmt = FMT_SH; opc = OP_IMM;    f3 = 3'b101; f7 = F7_ALT; end
      6'd23: begin fmt = FMT_SH; opc = OP_IMM;    f3 = 3'b101;          end
      6'd24: begin fmt = FMT_I;  opc = OP_IMM;    f3 = 3'b010;          end
      6'd25: begin fmt = FMT_I;  opc = OP_IMM;    f3 = 3'b011;          end
      6'd26: begin fmt = FMT_I;  opc = OP_JALR;   f3 = 3'b000;          end
      6'd27: begin fmt = FMT_S;  opc = OP_STORE;  f3 = 3'b010;          end
      6'd28: begin fmt = FMT_S;  opc = OP_STORE;  f3 = 3'b000;          end
      6'd29: begin fmt = FMT_S;  opc = OP_STORE;  f3 = 3'b001;          end
      6'd30: begin fmt = FMT_B;  opc = OP_BRANCH; f3 = 3'b000;          end
      6'd31: begin fmt = FMT_B;  opc = OP_BRANCH; f3 = 3'b001;          end
      6'd32: begin fmt = FMT_B;  opc = OP_BRANCH; f3 = 3'b100;          end
      6'd33: begin fmt = FMT_B;  opc = OP_BRANCH; f3 = 3'b101;          end
      6'd34: begin fmt = FMT_B;  opc = OP_BRANCH; f3 = 3'b110;          end
      6'd35: begin fmt = FMT_B;  opc = OP_BRANCH; f3 = 3'b111;          end
      6'd36: begin fmt = FMT_J;  opc = OP_JAL;                          end
      default: ;
    endcase
  end

  // Range checks are sign-extension tests: a value fits N signed bits when all
  // bits from N-1 upward are identical. Branch/jump offsets must also be even.
  always_comb begin
    legal = 1'b0;
    enc   = NOP;
    case (fmt)
      FMT_R: begin
        legal = 1'b1;
        enc   = {f7, in_rs2, in_rs1, f3, in_rd, opc};
      end
      FMT_I: begin
        legal = (&in_imm[31:11]) | ~(|in_imm[31:11]);
        enc   = {in_imm[11:0], in_rs1, f3, in_rd, opc};
      end
      FMT_SH: begin
        legal = ~(|in_imm[31:5]);
        enc   = {f7, in_imm[4:0], in_rs1, f3, in_rd, opc};
      end
      FMT_S: begin
        legal = (&in_imm[31:11]) | ~(|in_imm[31:11]);
        enc   = {in_imm[11:5], in_rs2, in_rs1, f3, in_imm[4:0], opc};
      end
      FMT_B: begin
        legal = ((&in_imm[31:12]) | ~(|in_imm[31:12])) & ~in_imm[0];
        enc   = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, f3, in_imm[4:1], in_imm[11], opc};
      end
      FMT_U: begin
        legal = ~(|in_imm[11:0]);
        enc   = {in_imm[31:12], in_rd, opc};
      end
      FMT_J: begin
        legal = ((&in_imm[31:20]) | ~(|in_imm[31:20])) & ~in_imm[0];
        enc   = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, opc};
      end
      default: ;
    endcase
  end

  assign in_ready = ~out_valid_q | out_ready;
  assign accept   = in_valid & in_ready;
  assign xfer     = out_valid_q & out_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_word_d  = out_word_q;
    out_err_d   = out_err_q;
    emit_cnt_d  = emit_cnt_q;
    err_cnt_d   = err_cnt_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_word_d  = legal ? enc : NOP;
      out_err_d   = ~legal;
    end else if (xfer) begin
      out_valid_d = 1'b0;
    end
    // Statistics follow what the consumer actually took, not what was accepted.
    if (xfer) begin
      emit_cnt_d = emit_cnt_q + CNT_W'(1);
      if (out_err_q && (err_cnt_q != '1)) begin
        err_cnt_d = err_cnt_q + ERR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_word_q  <= NOP;
      out_err_q   <= 1'b0;
      emit_cnt_q  <= '0;
      err_cnt_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_word_q  <= out_word_d;
      out_err_q   <= out_err_d;
      emit_cnt_q  <= emit_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_word  = out_word_q;
  assign out_err   = out_err_q;
  assign emit_cnt  = emit_cnt_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_mnem;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic        out_err;
  logic [15:0] emit_cnt;
  logic [7:0]  err_cnt;

  int n_chk = 0;
  int n_err = 0;

  typedef struct packed {logic [31:0] w; logic e;} exp_t;
  typedef enum int {TR, TI, TSH, TS, TB, TU, TJ, TX} tfmt_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  instr_encoder #(.CNT_W(16), .ERR_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mnem(in_mnem), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_word(out_word), .out_err(out_err),
    .emit_cnt(emit_cnt), .err_cnt(err_cnt)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  function automatic tfmt_t fmt_of(input logic [5:0] m);
    if (m <= 6'd1)       return TU;
    else if (m <= 6'd11) return TR;
    else if (m <= 6'd20) return TI;
    else if (m <= 6'd23) return TSH;
    else if (m <= 6'd26) return TI;
    else if (m <= 6'd29) return TS;
    else if (m <= 6'd35) return TB;
    else if (m == 6'd36) return TJ;
    return TX;
  endfunction

  // Reference encoder: ISA field tables plus signed-range legality.
  function automatic exp_t model(input logic [5:0] m, input logic [4:0] rd, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic [31:0] imm);
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    int s;
    logic ok;
    exp_t r;
    s  = $signed(imm);
    op = 7'h00; f3 = 3'd0; f7 = 7'h00;
    case (m)
      6'd0:  op = 7'h37;
      6'd1:  op = 7'h17;
      6'd2:  {op, f3, f7} = {7'h33, 3'd0, 7'h00};
      6'd3:  {op, f3, f7} = {7'h33, 3'd0, 7'h20};
      6'd4:  {op, f3, f7} = {7'h33, 3'd6, 7'h00};
      6'd5:  {op, f3, f7} = {7'h33, 3'd7, 7'h00};
      6'd6:  {op, f3, f7} = {7'h33, 3'd4, 7'h00};
      6'd7:  {op, f3, f7} = {7'h33, 3'd1, 7'h00};
      6'd8:  {op, f3, f7} = {7'h33, 3'd5, 7'h20};
      6'd9:  {op, f3, f7} = {7'h33, 3'd5, 7'h00};
      6'd10: {op, f3, f7} = {7'h33, 3'd2, 7'h00};
      6'd11: {op, f3, f7} = {7'h33, 3'd3, 7'h00};
      6'd12: {op, f3} = {7'h03, 3'd0};
      6'd13: {op, f3} = {7'h03, 3'd1};
      6'd14: {op, f3} = {7'h03, 3'd2};
      6'd15: {op, f3} = {7'h03, 3'd4};
      6'd16: {op, f3} = {7'h03, 3'd5};
      6'd17: {op, f3} = {7'h13, 3'd0};
      6'd18: {op, f3} = {7'h13, 3'd6};
      6'd19: {op, f3} = {7'h13, 3'd7};
      6'd20: {op, f3} = {7'h13, 3'd4};
      6'd21: {op, f3} = {7'h13, 3'd1};
      6'd22: {op, f3, f7} = {7'h13, 3'd5, 7'h20};
      6'd23: {op, f3} = {7'h13, 3'd5};
      6'd24: {op, f3} = {7'h13, 3'd2};
      6'd25: {op, f3} = {7'h13, 3'd3};
      6'd26: {op, f3} = {7'h67, 3'd0};
      6'd27: {op, f3} = {7'h23, 3'd2};
      6'd28: {op, f3} = {7'h23, 3'd0};
      6'd29: {op, f3} = {7'h23, 3'd1};
      6'd30: {op, f3} = {7'h63, 3'd0};
      6'd31: {op, f3} = {7'h63, 3'd1};
      6'd32: {op, f3} = {7'h63, 3'd4};
      6'd33: {op, f3} = {7'h63, 3'd5};
      6'd34: {op, f3} = {7'h63, 3'd6};
      6'd35: {op, f3} = {7'h63, 3'd7};
      6'd36: op = 7'h6F;
      default: ;
    endcase
    ok  = 1'b0;
    r.w = 32'h0000_0013;
    case (fmt_of(m))
      TR:  begin ok = 1'b1; r.w = {f7, rs2, rs1, f3, rd, op}; end
      TI:  begin ok = (s >= -2048) && (s <= 2047); r.w = {imm[11:0], rs1, f3, rd, op}; end
      TSH: begin ok = (s >= 0) && (s <= 31); r.w = {f7, imm[4:0], rs1, f3, rd, op}; end
      TS:  begin ok = (s >= -2048) && (s <= 2047); r.w = {imm[11:5], rs2, rs1, f3, imm[4:0], op}; end
      TB:  begin ok = (s >= -4096) && (s <= 4094) && !imm[0];
                 r.w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op}; end
      TU:  begin ok = (imm[11:0] == 12'd0); r.w = {imm[31:12], rd, op}; end
      TJ:  begin ok = (s >= -1048576) && (s <= 1048574) && !imm[0];
                 r.w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}; end
      default: ok = 1'b0;
    endcase
    if (!ok) r.w = 32'h0000_0013;
    r.e = !ok;
    return r;
  endfunction

  // Scoreboard: push on accept, pop and compare on output transfer.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("sb_word", out_word, e.w);
          check("sb_err", 32'(out_err), 32'(e.e));
        end
      end
      if (in_valid && in_ready) sb_q.push_back(model(in_mnem, in_rd, in_rs1, in_rs2, in_imm));
    end
  end

  task automatic set_req(input logic [5:0] m, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [31:0] imm);
    in_mnem = m; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
  endtask

  task automatic rand_req();
    logic [5:0]  m;
    logic [31:0] imm;
    m = 6'($urandom_range(0, 36));
    case (fmt_of(m))
      TI, TS: imm = 32'($urandom_range(0, 4095)) - 32'd2048;
      TSH:    imm = 32'($urandom_range(0, 31));
      TB:     imm = (32'($urandom_range(0, 4095)) - 32'd2048) << 1;
      TJ:     imm = (32'($urandom_range(0, 1048575)) - 32'd524288) << 1;
      TU:     imm = $urandom() & 32'hFFFF_F000;
      default: imm = $urandom();
    endcase
    set_req(m, 5'($urandom), 5'($urandom), 5'($urandom), imm);
  endtask

  // Present a request and hold it until accepted; returns just after the accepting edge.
  task automatic send(input logic [5:0] m, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] imm);
    int n;
    @(posedge clk); #1;
    set_req(m, rd, rs1, rs2, imm);
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("send_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_chk(input string tag, input logic [5:0] m, input logic [4:0] rd,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                          input logic [31:0] w, input logic e);
    send(m, rd, rs1, rs2, imm);
    @(negedge clk);
    check({tag, "_vld"}, 32'(out_valid), 32'd1);
    check({tag, "_word"}, out_word, w);
    check({tag, "_err"}, 32'(out_err), 32'(e));
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic stream_test();
    int sent;
    int cyc;
    logic acc;
    sent = 0;
    acc = 1'b0;
    cyc = 0;
    in_valid = 1'b0;
    while (cyc < 3000 && sent < 100) begin
      @(posedge clk); #1;
      if (acc) begin in_valid = 1'b0; acc = 1'b0; end
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid && $urandom_range(0, 2) != 0) begin
        rand_req();
        in_valid = 1'b1;
      end
      @(negedge clk);
      if (in_valid && in_ready) begin acc = 1'b1; sent++; end
      cyc++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("stream_sent", 32'(sent), 32'd100);
    check("stream_emit", 32'(emit_cnt), 32'd100);
    check("stream_err", 32'(err_cnt), 32'd0);
    check("stream_drain", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic wrap_test();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 65536; i++) begin
      @(posedge clk); #1;
      if (i < 300) set_req(6'd63, 5'($urandom), 5'($urandom), 5'($urandom), $urandom());
      else rand_req();
      in_valid = 1'b1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("wrap_emit", 32'(emit_cnt), 32'd0);
    check("sat_err", 32'(err_cnt), 32'd255);
    check("wrap_drain", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    set_req(6'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_vld", 32'(out_valid), 32'd0);
    check("rst_word", out_word, 32'h0000_0013);
    check("rst_err", 32'(out_err), 32'd0);
    check("rst_emit", 32'(emit_cnt), 32'd0);
    check("rst_errcnt", 32'(err_cnt), 32'd0);
    check("rst_rdy", 32'(in_ready), 32'd1);

    // Known encodings.
    send_chk("add",  6'd2,  5'd3, 5'd1, 5'd2, 32'd0,          32'h0020_81B3, 1'b0);
    send_chk("addi", 6'd17, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF,  32'hFFF0_0093, 1'b0);
    send_chk("sw",   6'd27, 5'd0, 5'd2, 5'd5, 32'd8,          32'h0051_2423, 1'b0);
    send_chk("beq",  6'd30, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC,  32'hFE20_8EE3, 1'b0);
    send_chk("jal",  6'd36, 5'd1, 5'd0, 5'd0, 32'd2048,       32'h0010_00EF, 1'b0);
    send_chk("srai", 6'd22, 5'd2, 5'd2, 5'd0, 32'd3,          32'h4031_5113, 1'b0);
    @(negedge clk);
    check("enc_emit", 32'(emit_cnt), 32'd6);

    // Error cases.
    do_reset();
    send_chk("e_addi", 6'd17, 5'd1, 5'd1, 5'd0, 32'd2048, 32'h0000_0013, 1'b1);
    send_chk("e_beq",  6'd30, 5'd0, 5'd1, 5'd2, 32'd3,    32'h0000_0013, 1'b1);
    send_chk("e_mnem", 6'd40, 5'd7, 5'd8, 5'd9, 32'd0,    32'h0000_0013, 1'b1);
    @(negedge clk);
    check("e_errcnt", 32'(err_cnt), 32'd3);
    check("e_emit", 32'(emit_cnt), 32'd3);

    // Backpressure: hold, then drain plus accept in the same cycle.
    do_reset();
    out_ready = 1'b0;
    send(6'd17, 5'd1, 5'd0, 5'd0, 32'd5);
    repeat (5) begin
      @(negedge clk);
      check("bp_rdy", 32'(in_ready), 32'd0);
      check("bp_vld", 32'(out_valid), 32'd1);
      check("bp_word", out_word, 32'h0050_0093);
      check("bp_emit_hold", 32'(emit_cnt), 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    set_req(6'd19, 5'd2, 5'd3, 5'd0, 32'hF);
    in_valid = 1'b1;
    @(negedge clk);
    check("bp_acc_rdy", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_new_vld", 32'(out_valid), 32'd1);
    check("bp_new_word", out_word, 32'h00F1_F113);
    check("bp_emit", 32'(emit_cnt), 32'd1);

    // Random streaming against the model.
    do_reset();
    stream_test();

    // Reset while a word is held.
    out_ready = 1'b0;
    send(6'd2, 5'd3, 5'd1, 5'd2, 32'd0);
    @(negedge clk);
    check("rh_vld_pre", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rh_vld", 32'(out_valid), 32'd0);
    check("rh_emit", 32'(emit_cnt), 32'd0);
    check("rh_errcnt", 32'(err_cnt), 32'd0);
    check("rh_rdy", 32'(in_ready), 32'd1);
    check("rh_word", out_word, 32'h0000_0013);

    // Counter wrap and saturation.
    wrap_test();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
